// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci sequence generator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  localparam int DEF_WIDTH = 32'd16;
  localparam int DEF_CNT_W = 32'd8;

  // Register contents after reset, mirroring the classic 0,1 start.
  localparam int SEED_A = 32'd0;
  localparam int SEED_B = 32'd1;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Control and stream signals of the Fibonacci generator, grouped as one bus.
interface fib_seq_gen_if
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic [WIDTH-1:0] seed_a;
  logic [WIDTH-1:0] seed_b;
  logic             abort;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             overflow;

  // Control/config master plus downstream consumer view.
  modport master (
    output start, n_terms, seed_a, seed_b, abort, out_ready,
    input  out_valid, out_data, out_last, busy, done, overflow
  );

  // Generator view.
  modport slave (
    input  start, n_terms, seed_a, seed_b, abort, out_ready,
    output out_valid, out_data, out_last, busy, done, overflow
  );

endinterface

// File: rtl/fib_seq_gen.sv
// Bounded Fibonacci-style term generator with valid/ready output and
// overflow-safe termination: a term that does not fit WIDTH bits is never shown.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  fib_seq_gen_if.slave bus
);

  fib_state_e       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             a_ovf_r;
  logic             b_ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             overflow_r;

  logic [WIDTH:0]   sum_s;
  logic             run_s;
  logic             xfer_s;

  // Next-term adder, one bit wider so a carry flags overflow.
  always_comb begin
    sum_s = {1'b0, a_r} + {1'b0, b_r};
  end

  assign run_s  = (state_r == RUN);
  assign xfer_s = run_s & ~a_ovf_r & bus.out_ready;

  assign bus.out_valid = run_s & ~a_ovf_r;
  assign bus.out_data  = run_s ? a_r : {WIDTH{1'b0}};
  assign bus.out_last  = run_s & ~a_ovf_r & (cnt_r == CNT_W'(1));
  assign bus.busy      = run_s;
  assign bus.done      = (state_r == DONE);
  assign bus.overflow  = overflow_r;

  // Run control FSM and term datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      a_r        <= WIDTH'(SEED_A);
      b_r        <= WIDTH'(SEED_B);
      a_ovf_r    <= 1'b0;
      b_ovf_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && (bus.n_terms != {CNT_W{1'b0}})) begin
            a_r        <= bus.seed_a;
            b_r        <= bus.seed_b;
            a_ovf_r    <= 1'b0;
            b_ovf_r    <= 1'b0;
            cnt_r      <= bus.n_terms;
            overflow_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          // abort outranks both normal completion and overflow detection
          if (bus.abort) begin
            state_r <= IDLE;
          end else if (a_ovf_r) begin
            overflow_r <= 1'b1;
            state_r    <= DONE;
          end else if (xfer_s) begin
            a_r     <= b_r;
            a_ovf_r <= b_ovf_r;
            b_r     <= sum_s[WIDTH-1:0];
            b_ovf_r <= sum_s[WIDTH] | b_ovf_r | a_ovf_r;
            cnt_r   <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: expected terms are queued from a software
// model when a run starts and popped on each accepted transfer.
module tb_fib_seq_gen;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fib_seq_gen_if #(.WIDTH(16), .CNT_W(8)) bus ();

  fib_seq_gen #(.WIDTH(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: queue the first `limit` of n terms; returns 1 if the run overflows.
  function automatic bit push_fib(input longint sa, input longint sb, input int n, input int limit);
    longint x;
    longint y;
    longint t;
    exp_t   e;
    x = sa;
    y = sb;
    for (int i = 0; i < n; i++) begin
      if (x > 65535) return 1'b1;
      if (i < limit) begin
        e.data = x[15:0];
        e.last = (i == n - 1);
        exp_q.push_back(e);
      end
      t = x + y;
      x = y;
      y = t;
    end
    return 1'b0;
  endfunction

  task automatic do_start(input logic [7:0] n, input logic [15:0] sa, input logic [15:0] sb);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.n_terms = n;
    bus.seed_a  = sa;
    bus.seed_b  = sb;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done, bus.overflow} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%0d last=%b busy=%b done=%b ovf=%b, expected all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done, bus.overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.busy, bus.done, bus.overflow} !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got valid=%b busy=%b done=%b ovf=%b, expected 0",
               bus.out_valid, bus.busy, bus.done, bus.overflow);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   cyc;
    bit   ovf_exp;
    ovf_exp = push_fib(0, 1, 10, 10);
    bus.out_ready = 1'b1;
    do_start(8'd10, 16'd0, 16'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL basic_term: got data=%0d last=%b, expected data=%0d last=%b",
                   bus.out_data, bus.out_last, e.data, e.last);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0 || cyc != 10) begin
      errors++;
      $display("FAIL basic_timing: got %0d cycles, %0d terms left, expected 10 cycles, 0 left", cyc, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.overflow !== ovf_exp || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b ovf=%b valid=%b busy=%b, expected done=1 ovf=%b valid=0 busy=0",
               bus.done, bus.overflow, bus.out_valid, bus.busy, ovf_exp);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, expected 0", bus.done);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    exp_t        e;
    int          cyc;
    bit          ovf_exp;
    bit          prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    ovf_exp = push_fib(0, 1, 10, 10);
    do_start(8'd10, 16'd0, 16'd1);
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = 16'd0;
    prev_last = 1'b0;
    while (exp_q.size() != 0 && cyc < 200) begin
      bus.out_ready = (cyc % 3 == 0);
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%0d last=%b, expected valid=1 data=%0d last=%b",
                   bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL bp_term: got data=%0d last=%b, expected data=%0d last=%b",
                   bus.out_data, bus.out_last, e.data, e.last);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.overflow !== ovf_exp) begin
      errors++;
      $display("FAIL bp_done: got %0d left done=%b ovf=%b, expected 0 left done=1 ovf=%b",
               exp_q.size(), bus.done, bus.overflow, ovf_exp);
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    exp_t e;
    int   cyc;
    int   xfers;
    bit   ovf_exp;
    ovf_exp = push_fib(0, 1, 255, 255);
    bus.out_ready = 1'b1;
    do_start(8'd255, 16'd0, 16'd1);
    cyc = 0;
    xfers = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        xfers++;
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL ovf_term: got data=%0d last=%b, expected data=%0d last=%b",
                   bus.out_data, bus.out_last, e.data, e.last);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (xfers != 25 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_count: got %0d terms, expected 25", xfers);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_hidden: got valid=%b busy=%b done=%b, expected valid=0 busy=1 done=0",
               bus.out_valid, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.overflow !== ovf_exp || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_done: got done=%b ovf=%b busy=%b, expected done=1 ovf=%b busy=0",
               bus.done, bus.overflow, bus.busy, ovf_exp);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got done=%b ovf=%b, expected done=0 ovf=1", bus.done, bus.overflow);
    end
  endtask

  task automatic test_zero_start();
    exp_t e;
    int   cyc;
    bit   ovf_exp;
    do_start(8'd0, 16'd3, 16'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
        errors++;
        $display("FAIL zero_start: got busy=%b done=%b valid=%b ovf=%b, expected 0 0 0 ovf=1",
                 bus.busy, bus.done, bus.out_valid, bus.overflow);
      end
    end
    ovf_exp = push_fib(5, 7, 3, 3);
    bus.out_ready = 1'b1;
    do_start(8'd3, 16'd5, 16'd7);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL seed57_term: got data=%0d last=%b, expected data=%0d last=%b",
                   bus.out_data, bus.out_last, e.data, e.last);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.overflow !== ovf_exp) begin
      errors++;
      $display("FAIL seed57_done: got %0d left done=%b ovf=%b, expected 0 left done=1 ovf=%b",
               exp_q.size(), bus.done, bus.overflow, ovf_exp);
    end
    exp_q.delete();
  endtask

  task automatic test_abort();
    exp_t e;
    int   cyc;
    bit   ovf_exp;
    ovf_exp = push_fib(0, 1, 10, 4);
    bus.out_ready = 1'b1;
    do_start(8'd10, 16'd0, 16'd1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL abort_term: got data=%0d last=%b, expected data=%0d last=%b",
                   bus.out_data, bus.out_last, e.data, e.last);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.overflow !== ovf_exp) begin
        errors++;
        $display("FAIL abort_idle: got busy=%b done=%b valid=%b ovf=%b, expected 0 0 0 ovf=%b",
                 bus.busy, bus.done, bus.out_valid, bus.overflow, ovf_exp);
      end
      @(posedge clk); #1;
    end
    ovf_exp = push_fib(2, 3, 4, 4);
    bus.out_ready = 1'b1;
    do_start(8'd4, 16'd2, 16'd3);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL restart_term: got data=%0d last=%b, expected data=%0d last=%b",
                   bus.out_data, bus.out_last, e.data, e.last);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: got %0d left done=%b, expected 0 left done=1", exp_q.size(), bus.done);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    int   cyc;
    bit   ovf_exp;
    bus.out_ready = 1'b0;
    do_start(8'd10, 16'd0, 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out_data !== 16'd0) begin
      errors++;
      $display("FAIL midrun_stall: got valid=%b busy=%b data=%0d, expected valid=1 busy=1 data=0",
               bus.out_valid, bus.busy, bus.out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done, bus.overflow} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b data=%0d last=%b busy=%b done=%b ovf=%b, expected all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done, bus.overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ovf_exp = push_fib(9, 4, 2, 2);
    bus.out_ready = 1'b1;
    do_start(8'd2, 16'd9, 16'd4);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL post_rst_term: got data=%0d last=%b, expected data=%0d last=%b",
                   bus.out_data, bus.out_last, e.data, e.last);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.done !== 1'b1 || bus.overflow !== ovf_exp) begin
      errors++;
      $display("FAIL post_rst_done: got %0d left done=%b ovf=%b, expected 0 left done=1 ovf=%b",
               exp_q.size(), bus.done, bus.overflow, ovf_exp);
    end
    exp_q.delete();
  endtask

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.n_terms   = 8'd0;
    bus.seed_a    = 16'd0;
    bus.seed_b    = 16'd0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_zero_start();
    test_abort();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
Parametrised Fibonacci-style sequence generator, successor to the fixed 16-bit enable-driven generator.
- Produces a bounded run of N terms from programmable seeds (a0, b0).
- Delivers terms over a valid/ready stream interface with backpressure and a last-term marker.
- Detects arithmetic overflow and terminates cleanly, so every emitted term is exact.
- Sits between a control/config master and a downstream stream consumer (FIFO, UART packer, checker).

Parameters:
WIDTH, 16, data width of seeds, terms and out_data
CNT_W, 8, width of the term-count field; max run length is 2^CNT_W-1

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to begin a run; sampled only in IDLE
n_terms  in  CNT_W  number of terms to emit; sampled with start
seed_a  in  WIDTH  first term; sampled with start
seed_b  in  WIDTH  second term; sampled with start
abort  in  1  cancels the current run
out_ready  in  1  downstream accepts out_data this cycle
out_valid  out  1  out_data holds a valid term
out_data  out  WIDTH  current term
out_last  out  1  qualifies out_valid; marks the final requested term
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at end of run, for both normal and overflow termination
overflow  out  1  sticky; run ended because the next term exceeded WIDTH bits

Behaviour:
- Reset (async): state=IDLE; a=0, b=1, a_ovf=0, b_ovf=0, cnt=0.
  - Outputs: out_valid=0, out_data=0, out_last=0, busy=0, done=0, overflow=0.
- States: IDLE, RUN, DONE (encoding defined in the package).
- IDLE:
  - start=1 and n_terms!=0: load a=seed_a, b=seed_b, cnt=n_terms, a_ovf=b_ovf=0, clear overflow; go to RUN.
  - start=1 and n_terms==0: ignored; stay in IDLE, no done pulse.
- Latency: start accepted at edge t gives out_valid=1 with out_data=seed_a from the cycle after t.
- RUN output functions:
  - out_data = a.
  - out_valid = ~a_ovf.
  - out_last = out_valid & (cnt==1).
  - busy = 1.
- Transfer occurs when out_valid & out_ready. On a transfer:
  - a<=b, a_ovf<=b_ovf.
  - b<=sum[WIDTH-1:0], where sum = a+b computed at WIDTH+1 bits.
  - b_ovf<=sum[WIDTH] | b_ovf | a_ovf.
  - cnt<=cnt-1.
- Run termination:
  - Transfer with cnt==1: go to DONE.
  - In RUN with a_ovf=1 (next term invalid): no transfer, overflow<=1, go to DONE. out_valid never asserts for an overflowed term.
- Backpressure: with out_valid=1 and out_ready=0, out_data, out_last and all state hold unchanged.
- DONE: done=1 for exactly one cycle, busy=0, out_valid=0; return to IDLE. overflow persists until the next accepted start or reset.
- abort:
  - In RUN, abort=1: go to IDLE next edge, no done pulse, overflow unchanged.
  - A transfer in the same cycle is considered completed by the consumer; no further terms follow.
  - abort is ignored in IDLE and DONE.
- Simultaneous events:
  - start during RUN or DONE is ignored.
  - start and abort together in IDLE: start wins.
- Seeds whose sum already overflows: first term still emitted; overflow is detected when that sum would become the current term.
- Reset mid-run: immediate return to reset values; any in-flight term is discarded.

Decomposition:
- Package fib_pkg:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH/CNT_W localparams
  - default seed constants SEED_A=0, SEED_B=1
- Single module; the datapath (a/b/ovf tracking) is too small to justify a sub-module.

Test Plan:
1. Seeds 0,1, n_terms=10, out_ready=1 -> out_data 0,1,1,2,3,5,8,13,21,34 on consecutive cycles; out_last only with 34; done one cycle later; overflow=0.
2. Same run, out_ready toggling 1,0,0,1,... -> identical 10-term sequence, data held stable during stalls, no duplicates or drops.
3. WIDTH=16, seeds 0,1, n_terms=255 -> 25 terms, 0..46368, emitted; 75025 never shown; overflow=1; done pulse; out_last never asserted.
4. start with n_terms=0 -> stays IDLE, busy=0, done=0. Then start with seeds 5,7, n_terms=3 -> 5,7,12, with last on 12.
5. Abort after the 4th transfer (seeds 0,1, n_terms=10) -> IDLE next cycle, no done, out_valid=0. A new start restarts cleanly.
6. Assert rst mid-run with out_ready=0 -> all outputs 0 immediately (async). After release, start yields seed_a first.
